// File: rtl/mmu_loader.sv
// Operand loader and result drainer for the 2x2 systolic multiplier.
// Its phases are LOAD, KICK, WAIT and DRAIN.
module mmu_loader #(
  parameter int DONE_MIN = 3,
  parameter int TIMEOUT  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] mmu_a,
  output logic [31:0] mmu_b,
  output logic        mmu_rst,
  input  logic [31:0] mmu_c,
  input  logic        mmu_done,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {LOAD, KICK, WAIT, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      drn_q, drn_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     res_q, res_d;
  logic            err_q, err_d;
  logic [7:0]      res_byte [4];
  logic            in_fire;
  logic            out_fire;
  logic            done_ok;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_res_byte
      assign res_byte[gi] = res_q[8*gi +: 8];
    end
  endgenerate

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q != LOAD);
  // The multiplier runs only while WAIT lasts. Reset keeps its cycle counter parked.
  assign mmu_rst   = (state_q != WAIT);
  assign mmu_a     = a_q;
  assign mmu_b     = b_q;
  assign err       = err_q;
  assign out_data  = res_byte[drn_q];

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  // The done flag survives the multiplier's reset, so it is ignored until it can be fresh.
  assign done_ok  = mmu_done && (cnt_q >= CW'(DONE_MIN));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      LOAD: begin
        if (in_fire) begin
          if (idx_q == 3'd0) err_d = 1'b0;
          if (idx_q[2]) b_d[{idx_q[1:0], 3'b000} +: 8] = in_data;
          else          a_d[{idx_q[1:0], 3'b000} +: 8] = in_data;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = KICK;
        end
      end
      KICK: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (done_ok) begin
          res_d   = mmu_c;
          drn_d   = 2'd0;
          state_d = DRAIN;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          err_d   = 1'b1;
          res_d   = '0;
          drn_d   = 2'd0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          drn_d = drn_q + 2'd1;
          if (drn_q == 2'd3) state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      idx_q   <= '0;
      cnt_q   <= '0;
      drn_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mmu_loader.sv
// Scoreboard bench for mmu_loader with a stub multiplier.
// The stub's done time is programmable: normal, stale-high or never.
module tb_mmu_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] mmu_a, mmu_b, mmu_c;
  logic        mmu_rst, mmu_done;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy, err;

  int          total = 0;
  int          bad   = 0;
  int          acc   = 0;
  logic [7:0]  exp_q [$];
  logic        exp_err = 1'b0;

  int          done_mode = 0;
  int          done_at   = 3;
  logic [31:0] stub_c    = '0;
  logic [7:0]  stub_cnt;

  always #5 clk = ~clk;

  mmu_loader #(.DONE_MIN(3), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mmu_a(mmu_a), .mmu_b(mmu_b), .mmu_rst(mmu_rst),
    .mmu_c(mmu_c), .mmu_done(mmu_done),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  // The stub counts the cycles since it left reset. Its result is valid from count 3.
  always @(posedge clk) begin
    if (mmu_rst) stub_cnt <= 8'd0;
    else         stub_cnt <= stub_cnt + 8'd1;
  end
  assign mmu_c    = (stub_cnt >= 8'd3) ? stub_c : 32'hDEAD_BEEF;
  assign mmu_done = (done_mode == 1) || (done_mode == 0 && int'(stub_cnt) >= done_at);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) chk("out_extra", 32'd1, 32'd0);
      else if (out_ready) begin
        chk("out_data", {24'd0, out_data}, {24'd0, exp_q[0]});
        $display("result byte %0d: %h", acc, out_data);
        void'(exp_q.pop_front());
        acc++;
      end else begin
        chk("out_hold", {24'd0, out_data}, {24'd0, exp_q[0]});
      end
    end
  end

  task automatic send_job(input logic [63:0] ops, input int mode, input int at,
                          input logic [31:0] c, input bit sparse);
    int   k = 0;
    int   guard = 0;
    bit   tmo;
    bit   chk_err = 1'b0;
    logic rdy;
    done_mode = mode;
    done_at   = at;
    stub_c    = c;
    tmo = (mode == 2) || (mode == 0 && at > 8);
    exp_err = tmo;
    for (int i = 0; i < 4; i++) exp_q.push_back(tmo ? 8'h00 : c[8*i +: 8]);
    $display("job ops=%h mode=%0d at=%0d c=%h", ops, mode, at, c);
    @(posedge clk); #1;
    while (k < 8 && guard < 200) begin
      guard++;
      in_data  = ops[8*k +: 8];
      in_valid = sparse ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      rdy = in_ready;
      chk("load_mmu_rst", {31'd0, mmu_rst}, 32'd1);
      if (chk_err) begin
        chk("err_clear", {31'd0, err}, 32'd0);
        chk_err = 1'b0;
      end
      @(posedge clk); #1;
      if (in_valid && rdy) begin
        k++;
        if (k == 1) chk_err = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (guard >= 200) chk("load_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("mmu_a", mmu_a, ops[31:0]);
    chk("mmu_b", mmu_b, ops[63:32]);
    chk("kick_rst", {31'd0, mmu_rst}, 32'd1);
    chk("kick_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("wait_rst", {31'd0, mmu_rst}, 32'd0);
  endtask

  task automatic drain(input logic [7:0] pat, input int plen, input bit poke);
    int i = 0;
    @(posedge clk); #1;
    if (poke) begin
      in_valid = 1'b1;
      in_data  = 8'hEE;
    end
    while (exp_q.size() > 0 && i < 200) begin
      out_ready = pat[i % plen];
      i++;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (i >= 200) chk("drain_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_in_ready", {31'd0, in_ready}, 32'd1);
    chk("end_out_valid", {31'd0, out_valid}, 32'd0);
    chk("end_err", {31'd0, err}, {31'd0, exp_err});
  endtask

  initial begin
    int base;
    int guard;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_mmu_rst", {31'd0, mmu_rst}, 32'd1);
    chk("rst_mmu_a", mmu_a, 32'd0);
    chk("rst_mmu_b", mmu_b, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    send_job(64'h0807_0605_0403_0201, 0, 3, 32'h2E2B_1713, 1'b0);
    drain(8'hFF, 1, 1'b0);

    send_job(64'h1122_3344_5566_7788, 1, 0, 32'hA5C3_0F96, 1'b0);
    drain(8'hFF, 1, 1'b0);

    send_job(64'h0F0E_0D0C_0B0A_0908, 2, 0, 32'h1234_5678, 1'b0);
    drain(8'hFF, 1, 1'b0);

    send_job(64'h8899_AABB_CCDD_EEFF, 0, 5, 32'h0102_7F80, 1'b1);
    drain(8'h69, 7, 1'b1);

    send_job(64'h2040_6080_A0C0_E0F0, 0, 8, 32'h5A6B_7C8D, 1'b0);
    drain(8'hFF, 1, 1'b0);

    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hC0 + 8'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midload_rst_a", mmu_a, 32'd0);
    chk("midload_rst_b", mmu_b, 32'd0);
    send_job(64'h7172_7374_7576_7778, 0, 4, 32'hCAFE_F00D, 1'b0);
    drain(8'hFF, 1, 1'b0);

    send_job(64'h0102_0304_0506_0708, 0, 3, 32'h0BAD_F00D, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    base  = acc;
    guard = 0;
    while (acc < base + 2 && guard < 100) begin
      guard++;
      @(posedge clk); #1;
    end
    if (guard >= 100) chk("drain_rst_timeout", 32'd0, 32'd1);
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("drain_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("drain_rst_busy", {31'd0, busy}, 32'd0);
    chk("drain_rst_mmu_rst", {31'd0, mmu_rst}, 32'd1);

    send_job(64'h1010_2020_3030_4040, 0, 3, 32'h3141_5926, 1'b0);
    drain(8'hFF, 1, 1'b0);
    send_job(64'h0A0B_0C0D_0E0F_1011, 0, 6, 32'h2718_2818, 1'b0);
    drain(8'h0B, 4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
